instr_stream_sequencer: RTL and testbench
=========================================

Name: instr_stream_sequencer

Overview:
- Sequences the instruction stream into the sodor5 core's imem response port during verification runs.
- Holds a small writable program table and replays it for a configured number of loops over a valid/ready handshake.
- Emits NOPs (addi x0,x0,0) while idle, in reset and after the program, to drain the 5-stage pipeline.
- Replaces free-running cycle-indexed program feeding with an explicit start/stop/done controller.

Parameters:
- PROG_DEPTH, 16, program table entries (power of two, >=2)
- WORD_SIZE, 32, instruction width
- CNT_W, 16, loop counter width
- FLUSH_NOPS, 5, NOPs issued after the last program beat before done

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- prog_wr_en  in  1  program table write strobe
- prog_wr_addr  in  $clog2(PROG_DEPTH)  write index
- prog_wr_data  in  WORD_SIZE  instruction to store
- prog_wr_err  out  1  one-cycle pulse: write dropped because busy
- cfg_len  in  $clog2(PROG_DEPTH)+1  instructions per loop, valid 1..PROG_DEPTH
- cfg_loops  in  CNT_W  loop count; 0 = run until stop
- start  in  1  begin run (sampled in IDLE only)
- stop  in  1  end run after current beat
- instr_valid  out  1  instr holds a beat
- instr_ready  in  1  core accepts beat
- instr  out  WORD_SIZE  instruction to core
- instr_idx  out  $clog2(PROG_DEPTH)  table index of current beat
- loop_cnt  out  CNT_W  completed loops
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse on run completion
- cfg_err  out  1  one-cycle pulse: start rejected (cfg_len 0 or > PROG_DEPTH)

Behaviour:
- States: IDLE, RUN, FLUSH, DONE. Reset (any state, mid-run included) -> IDLE, idx=0, loop_cnt=0, flush_cnt=0, all pulses 0, instr=NOP_INSTR (32'h00000013), instr_valid=0. Program table contents are NOT cleared by reset.
- All outputs come only from registered state and async table read. No combinational path from instr_ready to instr_valid.
- Handshake: beat transfers on a cycle with instr_valid & instr_ready. instr and instr_idx are held stable while valid & !ready.
- IDLE: instr=NOP, valid=0. Table writes are accepted.
  - start with legal cfg_len: latch cfg_len/cfg_loops, clear idx and loop_cnt, -> RUN.
  - start with illegal cfg_len: cfg_err pulse, stay in IDLE.
- RUN: valid=1, instr=table[idx]. On a transfer:
  - if idx==len-1: idx->0, loop_cnt++.
  - else idx++.
  - if the transfer completes loop number cfg_loops (cfg_loops!=0): -> FLUSH.
- stop in RUN:
  - with a transfer that cycle: -> FLUSH after that beat.
  - with no transfer: the pending beat still completes, then -> FLUSH. The stop request is latched.
  - stop outside RUN is ignored.
- FLUSH: valid=1, instr=NOP. Count transfers; after FLUSH_NOPS transfers -> DONE. FLUSH_NOPS=0 goes straight to DONE.
- DONE: single cycle, done=1, valid=0, -> IDLE. loop_cnt holds its value until the next start.
- prog_wr_en while busy: write dropped, prog_wr_err pulses. A write in the same cycle as an accepted start is committed before the first beat.
- loop_cnt saturates at all-ones when cfg_loops=0; it does not wrap.
- start and stop together in IDLE: start wins, stop ignored.

Optional Feature:
- Macro SEQ_CHECKSUM_EN.
- Defined: adds output issue_csum [WORD_SIZE]. On each RUN transfer, csum <= rotl(csum,1) ^ instr. NOP beats in FLUSH are excluded. Cleared on reset and on accepted start.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Package seq_pkg: state enum (IDLE/RUN/FLUSH/DONE), NOP_INSTR constant, WORD_SIZE default.
- One sub-module, prog_table: PROG_DEPTH x WORD_SIZE registers, sync write, async read, no reset.

Test Plan:
- Load 4 entries (0x00108093, 0x00210113, 0x00318193, 0x00420213), cfg_len=4, cfg_loops=2, ready=1 -> 8 beats in order, then 5 NOP beats, done pulse, loop_cnt=2.
- Same run, ready toggling 1-0-1 each cycle -> instr/instr_idx stable on stall cycles; same beat order; done after 13 transfers.
- cfg_loops=0, stop asserted after the 6th transfer -> FLUSH follows the 6th beat; loop_cnt=1 (len=4).
- Start with cfg_len=0, and separately with cfg_len=17 (PROG_DEPTH=16) -> cfg_err pulse, busy stays 0, valid stays 0.
- prog_wr_en during RUN -> prog_wr_err pulse, table unchanged (re-run yields the original beats).
- reset asserted mid-RUN at idx=2 -> next cycle IDLE, valid=0, instr=0x00000013; a new start replays from idx 0.

Source files
------------

// File: rtl/seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_pkg
// Description : Shared types and constants for the instruction stream
//               sequencer: controller state encoding, the pipeline-draining
//               NOP encoding and the default instruction width.
// Revision    : 1.0 - initial release
// ============================================================================
package seq_pkg;

  // Default instruction width (RV32I)
  localparam int DEF_WORD_SIZE = 32;

  // addi x0,x0,0 - canonical RISC-V NOP, used to drain the pipeline
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Controller states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } seq_state_e;

endpackage : seq_pkg
`default_nettype wire

// File: rtl/instr_stream_sequencer_prog_table.sv
`default_nettype none
// ============================================================================
// Module      : prog_table
// Description : DEPTH x WIDTH program store. Synchronous write, asynchronous
//               read, deliberately not reset so a loaded program survives a
//               sequencer reset.
// Revision    : 1.0 - initial release
// ============================================================================
module prog_table #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Table write port; contents are intentionally not reset
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule : prog_table
`default_nettype wire

// File: rtl/instr_stream_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : instr_stream_sequencer
// Description : Replays a writable program table into a core's instruction
//               port over a valid/ready handshake for a configured number of
//               loops, then drains the pipeline with NOPs and pulses done.
//               Optional feature macro: SEQ_CHECKSUM_EN adds issue_csum, a
//               rotate-xor signature over every program beat issued in RUN.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_stream_sequencer
  import seq_pkg::*;
#(
  parameter int  PROG_DEPTH = 16,
  parameter int  WORD_SIZE  = DEF_WORD_SIZE,
  parameter int  CNT_W      = 16,
  parameter int  FLUSH_NOPS = 5,
  localparam int AW         = $clog2(PROG_DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 prog_wr_en,
  input  logic [AW-1:0]        prog_wr_addr,
  input  logic [WORD_SIZE-1:0] prog_wr_data,
  output logic                 prog_wr_err,
  input  logic [AW:0]          cfg_len,
  input  logic [CNT_W-1:0]     cfg_loops,
  input  logic                 start,
  input  logic                 stop,
  output logic                 instr_valid,
  input  logic                 instr_ready,
  output logic [WORD_SIZE-1:0] instr,
  output logic [AW-1:0]        instr_idx,
  output logic [CNT_W-1:0]     loop_cnt,
  output logic                 busy,
  output logic                 done,
`ifdef SEQ_CHECKSUM_EN
  output logic [WORD_SIZE-1:0] issue_csum,
`endif
  output logic                 cfg_err
);

  localparam int              FW         = (FLUSH_NOPS > 1) ? $clog2(FLUSH_NOPS) : 1;
  localparam logic [FW-1:0]   FLUSH_LAST = FW'((FLUSH_NOPS > 0) ? FLUSH_NOPS - 1 : 0);
  localparam logic [AW:0]     LEN_MAX    = (AW+1)'(PROG_DEPTH);
  localparam logic [AW:0]     LEN_ONE    = (AW+1)'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [AW-1:0]   IDX_ONE    = AW'(1);
  localparam logic [FW-1:0]   FL_ONE     = FW'(1);
  // Where RUN goes when it ends; a zero-length flush skips FLUSH entirely
  localparam seq_state_e      RUN_EXIT   = (FLUSH_NOPS == 0) ? DONE : FLUSH;

  seq_state_e       state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0] loop_cnt_q, loop_cnt_d;
  logic [FW-1:0]    flush_q, flush_d;
  logic [AW:0]      len_q, len_d;
  logic [CNT_W-1:0] loops_q, loops_d;
  logic             stop_pend_q, stop_pend_d;
  logic             cfg_err_q, cfg_err_d;
  logic             wr_err_q, wr_err_d;
  logic             tbl_we;
  logic [WORD_SIZE-1:0] tbl_rd;
  logic             xfer, start_ok, last_beat, loops_done;
`ifdef SEQ_CHECKSUM_EN
  logic [WORD_SIZE-1:0] csum_q, csum_d;
`endif

  prog_table #(
    .DEPTH (PROG_DEPTH),
    .WIDTH (WORD_SIZE)
  ) u_prog_table (
    .clk       (clk),
    .wr_en_i   (tbl_we),
    .wr_addr_i (prog_wr_addr),
    .wr_data_i (prog_wr_data),
    .rd_addr_i (idx_q),
    .rd_data_o (tbl_rd)
  );

  assign xfer       = instr_valid & instr_ready;
  assign start_ok   = (cfg_len != '0) && (cfg_len <= LEN_MAX);
  assign last_beat  = ({1'b0, idx_q} == (len_q - LEN_ONE));
  assign loops_done = (loops_q != '0) && (loop_cnt_q == (loops_q - CNT_ONE));

  // Next-state, counters and pulse generation
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    loop_cnt_d  = loop_cnt_q;
    flush_d     = flush_q;
    len_d       = len_q;
    loops_d     = loops_q;
    stop_pend_d = stop_pend_q;
    cfg_err_d   = 1'b0;
    // Table is only writable while idle, including the cycle a start lands
    tbl_we      = prog_wr_en && (state_q == IDLE);
    wr_err_d    = prog_wr_en && (state_q != IDLE);
`ifdef SEQ_CHECKSUM_EN
    csum_d      = csum_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          if (start_ok) begin
            len_d       = cfg_len;
            loops_d     = cfg_loops;
            idx_d       = '0;
            loop_cnt_d  = '0;
            flush_d     = '0;
            stop_pend_d = 1'b0;
            state_d     = RUN;
`ifdef SEQ_CHECKSUM_EN
            csum_d      = '0;
`endif
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (stop) begin
          stop_pend_d = 1'b1;
        end
        if (xfer) begin
`ifdef SEQ_CHECKSUM_EN
          csum_d = {csum_q[WORD_SIZE-2:0], csum_q[WORD_SIZE-1]} ^ tbl_rd;
`endif
          if (last_beat) begin
            idx_d = '0;
            // Saturate rather than wrap in run-until-stop mode
            if (!(&loop_cnt_q)) begin
              loop_cnt_d = loop_cnt_q + CNT_ONE;
            end
          end else begin
            idx_d = idx_q + IDX_ONE;
          end
          if ((last_beat && loops_done) || stop || stop_pend_q) begin
            state_d     = RUN_EXIT;
            stop_pend_d = 1'b0;
          end
        end
      end
      FLUSH: begin
        if (xfer) begin
          if (flush_q == FLUSH_LAST) begin
            flush_d = '0;
            state_d = DONE;
          end else begin
            flush_d = flush_q + FL_ONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      loop_cnt_q  <= '0;
      flush_q     <= '0;
      len_q       <= '0;
      loops_q     <= '0;
      stop_pend_q <= 1'b0;
      cfg_err_q   <= 1'b0;
      wr_err_q    <= 1'b0;
`ifdef SEQ_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      loop_cnt_q  <= loop_cnt_d;
      flush_q     <= flush_d;
      len_q       <= len_d;
      loops_q     <= loops_d;
      stop_pend_q <= stop_pend_d;
      cfg_err_q   <= cfg_err_d;
      wr_err_q    <= wr_err_d;
`ifdef SEQ_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign instr_valid = (state_q == RUN) || (state_q == FLUSH);
  assign instr       = (state_q == RUN) ? tbl_rd : WORD_SIZE'(NOP_INSTR);
  assign instr_idx   = idx_q;
  assign loop_cnt    = loop_cnt_q;
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign cfg_err     = cfg_err_q;
  assign prog_wr_err = wr_err_q;
`ifdef SEQ_CHECKSUM_EN
  assign issue_csum  = csum_q;
`endif

endmodule : instr_stream_sequencer
`default_nettype wire

// File: tb/tb_instr_stream_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_stream_sequencer
// Description : Scoreboard bench for instr_stream_sequencer. Expected beats
//               are queued from a local copy of the program table and
//               compared as each handshake completes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_stream_sequencer;
  import seq_pkg::*;

  localparam int PD = 16;
  localparam int WS = 32;
  localparam int CW = 16;
  localparam int FN = 5;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          prog_wr_en = 1'b0;
  logic [AW-1:0] prog_wr_addr = '0;
  logic [WS-1:0] prog_wr_data = '0;
  logic          prog_wr_err;
  logic [AW:0]   cfg_len = '0;
  logic [CW-1:0] cfg_loops = '0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          instr_valid;
  logic          instr_ready = 1'b0;
  logic [WS-1:0] instr;
  logic [AW-1:0] instr_idx;
  logic [CW-1:0] loop_cnt;
  logic          busy;
  logic          done;
  logic          cfg_err;
`ifdef SEQ_CHECKSUM_EN
  logic [WS-1:0] issue_csum;
`endif

  instr_stream_sequencer #(
    .PROG_DEPTH (PD),
    .WORD_SIZE  (WS),
    .CNT_W      (CW),
    .FLUSH_NOPS (FN)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .prog_wr_en   (prog_wr_en),
    .prog_wr_addr (prog_wr_addr),
    .prog_wr_data (prog_wr_data),
    .prog_wr_err  (prog_wr_err),
    .cfg_len      (cfg_len),
    .cfg_loops    (cfg_loops),
    .start        (start),
    .stop         (stop),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr        (instr),
    .instr_idx    (instr_idx),
    .loop_cnt     (loop_cnt),
    .busy         (busy),
    .done         (done),
`ifdef SEQ_CHECKSUM_EN
    .issue_csum   (issue_csum),
`endif
    .cfg_err      (cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WS-1:0] instr;
    logic [AW-1:0] idx;
    bit            chk_idx;
  } beat_t;

  beat_t         sb_q[$];
  beat_t         mon_exp;
  logic [WS-1:0] prog [PD];
  int            tests_run = 0;
  int            tests_failed = 0;
  int            xfer_cnt = 0;

  // Scoreboard: every completed handshake pops and checks one expected beat
  always @(negedge clk) begin
    if (!reset && instr_valid && instr_ready) begin
      xfer_cnt++;
      tests_run++;
      if (sb_q.size() == 0) begin
        tests_failed++;
        $display("FAIL beat_unexpected: got instr=%h idx=%0d, required no beat", instr, instr_idx);
      end else begin
        mon_exp = sb_q.pop_front();
        if (instr !== mon_exp.instr || (mon_exp.chk_idx && instr_idx !== mon_exp.idx)) begin
          tests_failed++;
          $display("FAIL beat_order: got instr=%h idx=%0d, required instr=%h idx=%0d",
                   instr, instr_idx, mon_exp.instr, mon_exp.idx);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic write_prog(input logic [AW-1:0] a, input logic [WS-1:0] d);
    @(posedge clk); #1;
    prog_wr_en = 1'b1; prog_wr_addr = a; prog_wr_data = d;
    prog[a] = d;
    @(posedge clk); #1;
    prog_wr_en = 1'b0;
  endtask

  task automatic push_run(input int len, input int loops);
    for (int l = 0; l < loops; l++)
      for (int i = 0; i < len; i++)
        sb_q.push_back('{prog[i], AW'(i), 1'b1});
  endtask

  task automatic push_nops();
    for (int n = 0; n < FN; n++)
      sb_q.push_back('{WS'(NOP_INSTR), '0, 1'b0});
  endtask

  task automatic start_run(input int len, input int loops);
    @(posedge clk); #1;
    xfer_cnt = 0;
    cfg_len = (AW+1)'(len); cfg_loops = CW'(loops); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, output bit got);
    got = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin got = 1'b1; break; end
    end
  endtask

  // ---------------- test scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (instr_valid !== 1'b0 || instr !== WS'(NOP_INSTR) || busy !== 1'b0 || done !== 1'b0 ||
        loop_cnt !== '0 || instr_idx !== '0 || cfg_err !== 1'b0 || prog_wr_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: got valid=%b instr=%h busy=%b done=%b loop=%0d idx=%0d, required 0/00000013/0/0/0/0",
               instr_valid, instr, busy, done, loop_cnt, instr_idx);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    bit got;
    write_prog(0, 32'h0010_8093);
    write_prog(1, 32'h0021_0113);
    write_prog(2, 32'h0031_8193);
    write_prog(3, 32'h0042_0213);
    instr_ready = 1'b1;
    push_run(4, 2);
    push_nops();
    start_run(4, 2);
    wait_done(100, got);
    tests_run++;
    if (!got) begin tests_failed++; $display("FAIL basic_done: got no done, required done within 100 cycles"); end
    tests_run++;
    if (loop_cnt !== 16'd2 || xfer_cnt != 13 || sb_q.size() != 0) begin
      tests_failed++;
      $display("FAIL basic_counts: got loop=%0d xfers=%0d left=%0d, required 2/13/0", loop_cnt, xfer_cnt, sb_q.size());
    end
    @(posedge clk); #1;
    tests_run++;
    if (done !== 1'b0 || busy !== 1'b0 || instr_valid !== 1'b0 || loop_cnt !== 16'd2) begin
      tests_failed++;
      $display("FAIL basic_idle: got done=%b busy=%b valid=%b loop=%0d, required 0/0/0/2", done, busy, instr_valid, loop_cnt);
    end
  endtask

  task automatic test_stall();
    bit            got = 1'b0;
    bit            stalled = 1'b0;
    logic [WS-1:0] p_instr = '0;
    logic [AW-1:0] p_idx = '0;
    instr_ready = 1'b1;
    push_run(4, 2);
    push_nops();
    start_run(4, 2);
    for (int i = 0; i < 100; i++) begin
      if (stalled) begin
        tests_run++;
        if (instr !== p_instr || instr_idx !== p_idx) begin
          tests_failed++;
          $display("FAIL stall_hold: got instr=%h idx=%0d, required instr=%h idx=%0d", instr, instr_idx, p_instr, p_idx);
        end
      end
      if (done === 1'b1) begin got = 1'b1; break; end
      instr_ready = ~instr_ready;
      stalled = instr_valid && !instr_ready;
      p_instr = instr; p_idx = instr_idx;
      @(posedge clk); #1;
    end
    instr_ready = 1'b1;
    tests_run++;
    if (!got || xfer_cnt != 13 || loop_cnt !== 16'd2 || sb_q.size() != 0) begin
      tests_failed++;
      $display("FAIL stall_done: got done=%b xfers=%0d loop=%0d left=%0d, required 1/13/2/0", got, xfer_cnt, loop_cnt, sb_q.size());
    end
  endtask

  task automatic test_stop();
    bit got;
    bit found = 1'b0;
    instr_ready = 1'b1;
    push_run(4, 1);
    sb_q.push_back('{prog[0], 4'd0, 1'b1});
    sb_q.push_back('{prog[1], 4'd1, 1'b1});
    push_nops();
    start_run(4, 0);
    for (int i = 0; i < 50; i++) begin
      if (instr_valid && loop_cnt == 16'd1 && instr_idx == 4'd1) begin found = 1'b1; break; end
      @(posedge clk); #1;
    end
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    tests_run++;
    if (!found || instr !== WS'(NOP_INSTR) || instr_valid !== 1'b1 || loop_cnt !== 16'd1) begin
      tests_failed++;
      $display("FAIL stop_flush: got found=%b instr=%h valid=%b loop=%0d, required 1/00000013/1/1", found, instr, instr_valid, loop_cnt);
    end
    wait_done(50, got);
    tests_run++;
    if (!got || loop_cnt !== 16'd1 || xfer_cnt != 11 || sb_q.size() != 0) begin
      tests_failed++;
      $display("FAIL stop_done: got done=%b loop=%0d xfers=%0d left=%0d, required 1/1/11/0", got, loop_cnt, xfer_cnt, sb_q.size());
    end
  endtask

  task automatic test_stop_latched();
    bit got;
    bit found = 1'b0;
    instr_ready = 1'b1;
    for (int i = 0; i < 3; i++) sb_q.push_back('{prog[i], AW'(i), 1'b1});
    push_nops();
    start_run(4, 0);
    for (int i = 0; i < 50; i++) begin
      if (instr_valid && instr_idx == 4'd2) begin found = 1'b1; break; end
      @(posedge clk); #1;
    end
    instr_ready = 1'b0; stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    tests_run++;
    if (!found || instr !== prog[2] || instr_idx !== 4'd2 || instr_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL stop_pending: got found=%b instr=%h idx=%0d valid=%b, required 1/%h/2/1", found, instr, instr_idx, instr_valid, prog[2]);
    end
    instr_ready = 1'b1;
    wait_done(50, got);
    tests_run++;
    if (!got || loop_cnt !== 16'd0 || sb_q.size() != 0) begin
      tests_failed++;
      $display("FAIL stop_latched_done: got done=%b loop=%0d left=%0d, required 1/0/0", got, loop_cnt, sb_q.size());
    end
  endtask

  task automatic test_cfg_err();
    logic [AW:0] bad [2];
    bad[0] = 5'd0;
    bad[1] = 5'd17;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      cfg_len = bad[k]; cfg_loops = 16'd1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      tests_run++;
      if (cfg_err !== 1'b1 || busy !== 1'b0 || instr_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL cfg_err_pulse len=%0d: got err=%b busy=%b valid=%b, required 1/0/0", bad[k], cfg_err, busy, instr_valid);
      end
      @(posedge clk); #1;
      tests_run++;
      if (cfg_err !== 1'b0 || busy !== 1'b0 || instr_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL cfg_err_clear len=%0d: got err=%b busy=%b valid=%b, required 0/0/0", bad[k], cfg_err, busy, instr_valid);
      end
    end
  endtask

  task automatic test_wr_err();
    bit got;
    instr_ready = 1'b0;
    push_run(4, 1);
    push_nops();
    start_run(4, 1);
    prog_wr_en = 1'b1; prog_wr_addr = 4'd0; prog_wr_data = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    prog_wr_en = 1'b0;
    tests_run++;
    if (prog_wr_err !== 1'b1 || instr !== prog[0]) begin
      tests_failed++;
      $display("FAIL wr_err_pulse: got err=%b instr=%h, required 1/%h", prog_wr_err, instr, prog[0]);
    end
    @(posedge clk); #1;
    tests_run++;
    if (prog_wr_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL wr_err_clear: got err=%b, required 0", prog_wr_err);
    end
    instr_ready = 1'b1;
    wait_done(50, got);
    tests_run++;
    if (!got || sb_q.size() != 0) begin
      tests_failed++;
      $display("FAIL wr_err_run: got done=%b left=%0d, required 1/0", got, sb_q.size());
    end
    // A write landing with the start must be visible on the first loop
    prog[3] = 32'h0052_8293;
    push_run(4, 1);
    push_nops();
    @(posedge clk); #1;
    xfer_cnt = 0;
    cfg_len = 5'd4; cfg_loops = 16'd1; start = 1'b1;
    prog_wr_en = 1'b1; prog_wr_addr = 4'd3; prog_wr_data = 32'h0052_8293;
    @(posedge clk); #1;
    start = 1'b0; prog_wr_en = 1'b0;
    wait_done(50, got);
    tests_run++;
    if (!got || sb_q.size() != 0 || loop_cnt !== 16'd1) begin
      tests_failed++;
      $display("FAIL wr_with_start: got done=%b left=%0d loop=%0d, required 1/0/1", got, sb_q.size(), loop_cnt);
    end
  endtask

  task automatic test_reset_mid_run();
    bit got;
    bit found = 1'b0;
    instr_ready = 1'b1;
    sb_q.push_back('{prog[0], 4'd0, 1'b1});
    sb_q.push_back('{prog[1], 4'd1, 1'b1});
    start_run(4, 1);
    for (int i = 0; i < 50; i++) begin
      if (instr_valid && instr_idx == 4'd2) begin found = 1'b1; break; end
      @(posedge clk); #1;
    end
    reset = 1'b1; instr_ready = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if (!found || instr_valid !== 1'b0 || instr !== WS'(NOP_INSTR) || busy !== 1'b0 ||
        instr_idx !== '0 || loop_cnt !== '0 || sb_q.size() != 0) begin
      tests_failed++;
      $display("FAIL reset_mid_run: got found=%b valid=%b instr=%h busy=%b idx=%0d loop=%0d left=%0d, required 1/0/00000013/0/0/0/0",
               found, instr_valid, instr, busy, instr_idx, loop_cnt, sb_q.size());
    end
    reset = 1'b0;
    instr_ready = 1'b1;
    push_run(4, 1);
    push_nops();
    start_run(4, 1);
    wait_done(50, got);
    tests_run++;
    if (!got || sb_q.size() != 0 || loop_cnt !== 16'd1 || xfer_cnt != 9) begin
      tests_failed++;
      $display("FAIL reset_replay: got done=%b left=%0d loop=%0d xfers=%0d, required 1/0/1/9", got, sb_q.size(), loop_cnt, xfer_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_stop();
    test_stop_latched();
    test_cfg_err();
    test_wr_err();
    test_reset_mid_run();
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_instr_stream_sequencer
`default_nettype wire
